// File: rtl/wishbone_bus_arbiter_pkg.sv
// Shared types and the round-robin selection helper for the Wishbone bus arbiter.
package wishbone_bus_arbiter_pkg;

    // Upper bound on master count supported by the selection helper.
    localparam int unsigned MAX_MASTERS = 32;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arbiter_state_e;

    // One-hot pick of the first requester at or after pointer, wrapping modulo masters.
    function automatic logic [MAX_MASTERS-1:0] next_grant(
        input logic [MAX_MASTERS-1:0] req,
        input int unsigned            pointer,
        input int unsigned            masters
    );
        logic [MAX_MASTERS-1:0] grant;
        logic                   found;
        logic [4:0]             idx;
        grant = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_MASTERS; k++) begin
            if (k < masters) begin
                idx = 5'((pointer + k) % masters);
                if (!found && req[idx]) begin
                    grant[idx] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/wishbone_bus_arbiter_if.sv
// Wishbone B4 bus bundle with master and slave views.
interface wishbone_bus_arbiter_if #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32
);
    logic                      cyc;
    logic                      stb;
    logic                      stall;
    logic [ADDRESS_WIDTH-1:0]  adr;
    logic                      we;
    logic [DATA_WIDTH-1:0]     dat_w;
    logic [DATA_WIDTH/8-1:0]   sel;
    logic                      ack;
    logic                      err;
    logic                      rty;
    logic [DATA_WIDTH-1:0]     dat_r;

    modport master (
        output cyc, stb, adr, we, dat_w, sel,
        input  stall, ack, err, rty, dat_r
    );

    modport slave (
        input  cyc, stb, adr, we, dat_w, sel,
        output stall, ack, err, rty, dat_r
    );
endinterface

// File: rtl/wishbone_rr_arbiter_core.sv
// Pure combinational round-robin selector: first request at/after the pointer wins.
module wishbone_rr_arbiter_core
    import wishbone_bus_arbiter_pkg::*;
#(
    parameter int unsigned MASTERS = 2,
    localparam int unsigned PTR_W  = $clog2(MASTERS)
) (
    input  logic [MASTERS-1:0] req,
    input  logic [PTR_W-1:0]   pointer,
    output logic [MASTERS-1:0] grant
);

    logic [MAX_MASTERS-1:0] req_wide;
    logic [MAX_MASTERS-1:0] grant_wide;

    // Widen to the helper's fixed width, select, then narrow back.
    always_comb begin
        req_wide              = '0;
        req_wide[MASTERS-1:0] = req;
        grant_wide            = next_grant(req_wide, 32'(pointer), MASTERS);
        grant                 = grant_wide[MASTERS-1:0];
    end

    if (MASTERS < MAX_MASTERS) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^grant_wide[MAX_MASTERS-1:MASTERS];
    end

endmodule

// File: rtl/wishbone_bus_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave among MASTERS masters.
// Grant is held for a whole bus cycle; one IDLE cycle separates consecutive grants.
module wishbone_bus_arbiter
    import wishbone_bus_arbiter_pkg::*;
#(
    parameter int unsigned MASTERS       = 2,
    parameter bit          USE_STALL     = 1'b1,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    wishbone_bus_arbiter_if.slave  wishbone_if_s [MASTERS-1:0],
    wishbone_bus_arbiter_if.master wishbone_if_m,
    output logic [MASTERS-1:0]    o_grant
);

    localparam int unsigned PTR_W = $clog2(MASTERS);
    localparam int unsigned SEL_W = DATA_WIDTH / 8;

    arbiter_state_e           state_q, state_d;
    logic [MASTERS-1:0]       grant_q, grant_d;
    logic [PTR_W-1:0]         pointer_q, pointer_d;
    logic [PTR_W-1:0]         grant_idx;
    logic [MASTERS-1:0]       req;
    logic [MASTERS-1:0]       arb_grant;
    logic                     granted_cyc;
    logic                     slave_stall;

    logic [MASTERS-1:0]       m_stb;
    logic [MASTERS-1:0]       m_we;
    logic [ADDRESS_WIDTH-1:0] m_adr   [MASTERS];
    logic [DATA_WIDTH-1:0]    m_dat_w [MASTERS];
    logic [SEL_W-1:0]         m_sel   [MASTERS];

    assign slave_stall = USE_STALL ? wishbone_if_m.stall : 1'b0;

    // Flatten master requests and fan the slave response back out.
    // grant_q is only non-zero in BUSY, so it alone qualifies the return path.
    for (genvar i = 0; i < MASTERS; i++) begin : g_port
        assign req[i]     = wishbone_if_s[i].cyc;
        assign m_stb[i]   = wishbone_if_s[i].stb;
        assign m_we[i]    = wishbone_if_s[i].we;
        assign m_adr[i]   = wishbone_if_s[i].adr;
        assign m_dat_w[i] = wishbone_if_s[i].dat_w;
        assign m_sel[i]   = wishbone_if_s[i].sel;

        assign wishbone_if_s[i].ack   = grant_q[i] & wishbone_if_m.ack;
        assign wishbone_if_s[i].err   = grant_q[i] & wishbone_if_m.err;
        assign wishbone_if_s[i].rty   = grant_q[i] & wishbone_if_m.rty;
        assign wishbone_if_s[i].stall = grant_q[i] ? slave_stall : 1'b1;
        assign wishbone_if_s[i].dat_r = wishbone_if_m.dat_r;
    end

    wishbone_rr_arbiter_core #(
        .MASTERS (MASTERS)
    ) u_core (
        .req     (req),
        .pointer (pointer_q),
        .grant   (arb_grant)
    );

    // Encode the one-hot grant into an index for the mux and pointer update.
    always_comb begin
        grant_idx = '0;
        for (int unsigned i = 0; i < MASTERS; i++) begin
            if (grant_q[i]) begin
                grant_idx = PTR_W'(i);
            end
        end
    end

    assign granted_cyc = |(req & grant_q);

    // Next-state: arbitrate in IDLE, hold grant until the owner drops cyc.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        pointer_d = pointer_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d = arb_grant;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!granted_cyc) begin
                    grant_d   = '0;
                    state_d   = IDLE;
                    pointer_d = (grant_idx == PTR_W'(MASTERS - 1)) ? '0 : grant_idx + 1'b1;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State, grant and priority pointer registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            pointer_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            pointer_q <= pointer_d;
        end
    end

    // Forward the owner's request fields; IDLE keeps control strobes low.
    always_comb begin
        wishbone_if_m.cyc   = 1'b0;
        wishbone_if_m.stb   = 1'b0;
        wishbone_if_m.we    = 1'b0;
        wishbone_if_m.adr   = m_adr[0];
        wishbone_if_m.dat_w = m_dat_w[0];
        wishbone_if_m.sel   = m_sel[0];
        if (state_q == BUSY) begin
            wishbone_if_m.cyc   = granted_cyc;
            wishbone_if_m.stb   = m_stb[grant_idx];
            wishbone_if_m.we    = m_we[grant_idx];
            wishbone_if_m.adr   = m_adr[grant_idx];
            wishbone_if_m.dat_w = m_dat_w[grant_idx];
            wishbone_if_m.sel   = m_sel[grant_idx];
        end
    end

    assign o_grant = grant_q;

endmodule
